// File: rtl/bsg_counter_up_down_one_hot_if.sv
// Interface between a credit producer/consumer and the one-hot up/down counter.
// With BSG_COUNTER_UP_DOWN_ONE_HOT_ERR_EN defined it also carries the sticky error flag.
interface bsg_counter_up_down_one_hot_if #(
    parameter int max_val_p = 32
);
    // A zero-width binary count is illegal, so the degenerate max_val_p=0 case keeps one bit.
    localparam int lg_width_lp = (max_val_p == 0) ? 1 : $clog2(max_val_p + 1);

    logic                   clear_i;
    logic                   up_i;
    logic                   down_i;
    logic [max_val_p:0]     count_r_o;
    logic [lg_width_lp-1:0] count_bin_o;
    logic                   zero_o;
    logic                   full_o;
`ifdef BSG_COUNTER_UP_DOWN_ONE_HOT_ERR_EN
    logic                   err_r_o;

    modport master (
        output clear_i, up_i, down_i,
        input  count_r_o, count_bin_o, zero_o, full_o, err_r_o
    );
    modport slave (
        input  clear_i, up_i, down_i,
        output count_r_o, count_bin_o, zero_o, full_o, err_r_o
    );
`else
    modport master (
        output clear_i, up_i, down_i,
        input  count_r_o, count_bin_o, zero_o, full_o
    );
    modport slave (
        input  clear_i, up_i, down_i,
        output count_r_o, count_bin_o, zero_o, full_o
    );
`endif
endinterface

// File: rtl/bsg_counter_up_down_one_hot.sv
// Saturating one-hot credit counter with binary view and zero/full flags.
// Optional sticky protocol-error flag under BSG_COUNTER_UP_DOWN_ONE_HOT_ERR_EN.
module bsg_counter_up_down_one_hot #(
    parameter int max_val_p  = 32,
    parameter int init_val_p = max_val_p
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    bsg_counter_up_down_one_hot_if.slave  bus
);
    localparam int lg_width_lp = (max_val_p == 0) ? 1 : $clog2(max_val_p + 1);
    localparam logic [max_val_p:0] init_oh_lp = (max_val_p + 1)'(1) << init_val_p;

    logic [max_val_p:0]     r_count;
    logic [lg_width_lp-1:0] w_bin;
    logic                   w_up_only;
    logic                   w_down_only;
    logic                   w_zero;
    logic                   w_full;

    assign w_up_only   = bus.up_i & ~bus.down_i;
    assign w_down_only = bus.down_i & ~bus.up_i;
    assign w_zero      = r_count[0];
    assign w_full      = r_count[max_val_p];

    always_ff @(posedge clk_i) begin
        if (reset_i || bus.clear_i) begin
            r_count <= init_oh_lp;
        end else if (w_up_only && !w_full) begin
            r_count <= r_count << 1;
        end else if (w_down_only && !w_zero) begin
            r_count <= r_count >> 1;
        end
    end

    // Pure OR encoder: relies on exactly one bit being hot, no priority chain.
    always_comb begin
        w_bin = '0;
        for (int k = 0; k <= max_val_p; k++) begin
            w_bin = w_bin | (r_count[k] ? lg_width_lp'(k) : '0);
        end
    end

    assign bus.count_r_o   = r_count;
    assign bus.count_bin_o = w_bin;
    assign bus.zero_o      = w_zero;
    assign bus.full_o      = w_full;

`ifdef BSG_COUNTER_UP_DOWN_ONE_HOT_ERR_EN
    logic r_err;
    logic w_viol;

    assign w_viol = (w_up_only && w_full) || (w_down_only && w_zero);

    always_ff @(posedge clk_i) begin
        if (reset_i || bus.clear_i) begin
            r_err <= 1'b0;
        end else if (w_viol) begin
            r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i && !bus.clear_i && w_viol) begin
            $error("bsg_counter_up_down_one_hot: %s while %s", w_up_only ? "up" : "down",
                   w_up_only ? "full" : "zero");
        end
    end

    assign bus.err_r_o = r_err;
`endif
endmodule

// File: tb/tb_bsg_counter_up_down_one_hot.sv
// Self-checking bench: directed scenarios on a 0..4 counter (init 4), random walk on a
// 0..4 counter (init 0) and the degenerate max_val_p=0 counter, against an integer model.
module tb_bsg_counter_up_down_one_hot;
    logic clk_i = 1'b0;
    logic reset_i;

    int errors = 0;
    int checks = 0;
    int m_a;
    int m_b;

    bsg_counter_up_down_one_hot_if #(.max_val_p(4)) if_a ();
    bsg_counter_up_down_one_hot_if #(.max_val_p(4)) if_b ();
    bsg_counter_up_down_one_hot_if #(.max_val_p(0)) if_c ();

    bsg_counter_up_down_one_hot #(.max_val_p(4), .init_val_p(4)) dut_a (
        .clk_i(clk_i), .reset_i(reset_i), .bus(if_a));
    bsg_counter_up_down_one_hot #(.max_val_p(4), .init_val_p(0)) dut_b (
        .clk_i(clk_i), .reset_i(reset_i), .bus(if_b));
    bsg_counter_up_down_one_hot #(.max_val_p(0), .init_val_p(0)) dut_c (
        .clk_i(clk_i), .reset_i(reset_i), .bus(if_c));

    always #5 clk_i = ~clk_i;

    // Behavioural count: plain integer with saturation and reset/clear priority.
    function automatic int model_next(int cnt, bit rst, bit clr, bit up, bit dn, int maxv, int initv);
        if (rst || clr) return initv;
        if (up && !dn && cnt < maxv) return cnt + 1;
        if (dn && !up && cnt > 0) return cnt - 1;
        return cnt;
    endfunction

    // One clock on counter A; B and C idle (they only see reset).
    task automatic step_a(bit r, bit c, bit u, bit d);
        reset_i     = r;
        if_a.clear_i = c;
        if_a.up_i    = u;
        if_a.down_i  = d;
        @(posedge clk_i);
        #1;
        m_a = model_next(m_a, r, c, u, d, 4, 4);
        m_b = model_next(m_b, r, 1'b0, 1'b0, 1'b0, 4, 0);
    endtask

    task automatic test_reset();
        step_a(1, 0, 1, 0);
        step_a(1, 0, 0, 1);
        step_a(0, 0, 0, 0);
        checks++;
        if (if_a.count_r_o !== 5'b10000) begin
            errors++; $display("FAIL reset_onehot: got %b want 10000", if_a.count_r_o);
        end
        checks++;
        if (if_a.count_bin_o !== 3'd4) begin
            errors++; $display("FAIL reset_bin: got %0d want 4", if_a.count_bin_o);
        end
        checks++;
        if (if_a.full_o !== 1'b1 || if_a.zero_o !== 1'b0) begin
            errors++; $display("FAIL reset_flags: got full=%b zero=%b want full=1 zero=0", if_a.full_o, if_a.zero_o);
        end
        checks++;
        if (if_b.count_r_o !== 5'b00001 || if_b.zero_o !== 1'b1 || if_b.full_o !== 1'b0) begin
            errors++; $display("FAIL reset_init0: got %b zero=%b full=%b want 00001 zero=1 full=0",
                               if_b.count_r_o, if_b.zero_o, if_b.full_o);
        end
        checks++;
        if (if_c.count_r_o !== 1'b1 || if_c.zero_o !== 1'b1 || if_c.full_o !== 1'b1) begin
            errors++; $display("FAIL reset_max0: got %b zero=%b full=%b want 1 1 1",
                               if_c.count_r_o, if_c.zero_o, if_c.full_o);
        end
`ifdef BSG_COUNTER_UP_DOWN_ONE_HOT_ERR_EN
        checks++;
        if (if_a.err_r_o !== 1'b0) begin
            errors++; $display("FAIL reset_err: got %b want 0", if_a.err_r_o);
        end
`endif
    endtask

    task automatic test_down_to_zero();
        int exp_bin[5] = '{3, 2, 1, 0, 0};
        for (int i = 0; i < 5; i++) begin
            step_a(0, 0, 0, 1);
            checks++;
            if (if_a.count_bin_o !== 3'(exp_bin[i]) || if_a.count_r_o !== (5'b00001 << exp_bin[i])) begin
                errors++; $display("FAIL down_step%0d: got bin=%0d oh=%b want bin=%0d",
                                   i, if_a.count_bin_o, if_a.count_r_o, exp_bin[i]);
            end
            checks++;
            if (if_a.zero_o !== (exp_bin[i] == 0) || if_a.full_o !== 1'b0) begin
                errors++; $display("FAIL down_flags%0d: got zero=%b full=%b want zero=%0d full=0",
                                   i, if_a.zero_o, if_a.full_o, exp_bin[i] == 0);
            end
        end
`ifdef BSG_COUNTER_UP_DOWN_ONE_HOT_ERR_EN
        checks++;
        if (if_a.err_r_o !== 1'b1) begin
            errors++; $display("FAIL down_err: got %b want 1", if_a.err_r_o);
        end
`endif
    endtask

    task automatic test_up_down_hold();
        step_a(0, 0, 1, 0);
        step_a(0, 0, 1, 0);
        checks++;
        if (if_a.count_bin_o !== 3'd2) begin
            errors++; $display("FAIL climb_to_2: got %0d want 2", if_a.count_bin_o);
        end
        for (int i = 0; i < 3; i++) begin
            step_a(0, 0, 1, 1);
            checks++;
            if (if_a.count_r_o !== 5'b00100) begin
                errors++; $display("FAIL both_hold%0d: got %b want 00100", i, if_a.count_r_o);
            end
        end
        step_a(0, 0, 1, 0);
        step_a(0, 0, 1, 0);
        checks++;
        if (if_a.count_bin_o !== 3'd4 || if_a.full_o !== 1'b1) begin
            errors++; $display("FAIL up_to_full: got bin=%0d full=%b want 4 1", if_a.count_bin_o, if_a.full_o);
        end
        step_a(0, 0, 1, 0);
        checks++;
        if (if_a.count_r_o !== 5'b10000 || if_a.count_bin_o !== 3'd4) begin
            errors++; $display("FAIL up_sat: got %b bin=%0d want 10000 4", if_a.count_r_o, if_a.count_bin_o);
        end
        step_a(0, 0, 1, 1);
        checks++;
        if (if_a.count_r_o !== 5'b10000) begin
            errors++; $display("FAIL both_at_full: got %b want 10000", if_a.count_r_o);
        end
    endtask

    task automatic test_clear_priority();
        for (int i = 0; i < 3; i++) step_a(0, 0, 0, 1);
        checks++;
        if (if_a.count_bin_o !== 3'd1) begin
            errors++; $display("FAIL pre_clear: got %0d want 1", if_a.count_bin_o);
        end
        step_a(0, 1, 0, 1);
        checks++;
        if (if_a.count_bin_o !== 3'd4 || if_a.count_r_o !== 5'b10000) begin
            errors++; $display("FAIL clear_wins: got bin=%0d oh=%b want 4 10000", if_a.count_bin_o, if_a.count_r_o);
        end
`ifdef BSG_COUNTER_UP_DOWN_ONE_HOT_ERR_EN
        checks++;
        if (if_a.err_r_o !== 1'b0) begin
            errors++; $display("FAIL clear_err: got %b want 0", if_a.err_r_o);
        end
`endif
    endtask

    task automatic test_reset_priority();
        step_a(0, 0, 0, 1);
        checks++;
        if (if_a.count_bin_o !== 3'd3) begin
            errors++; $display("FAIL pre_reset: got %0d want 3", if_a.count_bin_o);
        end
        step_a(1, 0, 1, 0);
        checks++;
        if (if_a.count_bin_o !== 3'd4 || if_a.count_r_o !== 5'b10000) begin
            errors++; $display("FAIL reset_wins: got bin=%0d oh=%b want 4 10000", if_a.count_bin_o, if_a.count_r_o);
        end
        reset_i = 1'b0;
    endtask

    task automatic test_random();
        bit u, d, c;
        m_b = 0;
        for (int n = 0; n < 10000; n++) begin
            u = 1'($urandom_range(0, 1));
            d = 1'($urandom_range(0, 1));
            c = ($urandom_range(0, 63) == 0);
            if_b.up_i = u; if_b.down_i = d; if_b.clear_i = c;
            if_c.up_i = u; if_c.down_i = d; if_c.clear_i = 1'b0;
            @(posedge clk_i);
            #1;
            m_b = model_next(m_b, 1'b0, c, u, d, 4, 0);
            checks++;
            if (if_b.count_bin_o !== 3'(m_b) || if_b.count_r_o !== (5'b00001 << m_b)
                || !$onehot(if_b.count_r_o)) begin
                errors++; $display("FAIL rand_count cyc%0d: got bin=%0d oh=%b want %0d",
                                   n, if_b.count_bin_o, if_b.count_r_o, m_b);
            end
            checks++;
            if (if_b.zero_o !== (m_b == 0) || if_b.full_o !== (m_b == 4)) begin
                errors++; $display("FAIL rand_flags cyc%0d: got zero=%b full=%b want count %0d",
                                   n, if_b.zero_o, if_b.full_o, m_b);
            end
            checks++;
            if (if_c.count_r_o !== 1'b1 || if_c.count_bin_o !== 1'b0 || if_c.zero_o !== 1'b1 || if_c.full_o !== 1'b1) begin
                errors++; $display("FAIL rand_max0 cyc%0d: got oh=%b bin=%0d zero=%b full=%b want 1 0 1 1",
                                   n, if_c.count_r_o, if_c.count_bin_o, if_c.zero_o, if_c.full_o);
            end
        end
        if_b.up_i = 1'b0; if_b.down_i = 1'b0; if_b.clear_i = 1'b0;
        if_c.up_i = 1'b0; if_c.down_i = 1'b0;
    endtask

    initial begin
        reset_i = 1'b1;
        if_a.clear_i = 1'b0; if_a.up_i = 1'b0; if_a.down_i = 1'b0;
        if_b.clear_i = 1'b0; if_b.up_i = 1'b0; if_b.down_i = 1'b0;
        if_c.clear_i = 1'b0; if_c.up_i = 1'b0; if_c.down_i = 1'b0;
        m_a = 0;
        m_b = 0;
        #2;
        test_reset();
        test_down_to_zero();
        test_up_down_hold();
        test_clear_priority();
        test_reset_priority();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
